alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Parametrised, sequential successor to the single-cycle ALU control/datapath pair.
- Decodes the MIPS R-type funct field and executes logic, arithmetic, compare and shift ops in one registered cycle.
- Executes MULTU as an iterative shift-add over WIDTH cycles into architectural HI/LO registers; MFHI/MFLO read them back.
- Sits in the EX stage of the multicycle CPU and stalls issue through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), width of the shift amount taken from B[SHW-1:0].

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  op request; accepted only when busy=0.
- A  input  WIDTH  operand A (shift target for SLL/SRL).
- B  input  WIDTH  operand B (shift amount in B[SHW-1:0]).
- sel  input  6  funct code.
- result  output  WIDTH  registered result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse: result/hi/lo valid.
- overflow  output  1  signed overflow of the last ADD/SUB.
- illegal  output  1  last accepted sel was unsupported.

Behaviour:
- Reset (sync, rst=1 at posedge): result=0, hi=0, lo=0, busy=0, done=0, overflow=0, illegal=0, FSM=IDLE, iteration counter=0. Reset has priority over start and aborts any multiply; no partial HI/LO is kept.
- Funct codes:
  - AND 100100
  - OR 100101
  - ADD 100000
  - SUB 100010
  - SLT 101010
  - SLL 000000
  - SRL 000010
  - MULTU 011001
  - MFHI 010000
  - MFLO 010010
  - Any other code is illegal.
- Operands and sel are latched at accept; they may change afterwards without effect.
- FSM states: IDLE, MUL.
- IDLE, start=1, single-cycle op:
  - At the accepting edge: result updated, done=1 for the following cycle, stay IDLE (latency 1).
  - overflow is updated only by ADD/SUB. It is 1 when the operand signs match (ADD) or differ (SUB) and the result sign differs from A.
  - illegal is updated on every accept.
- ADD/SUB: WIDTH-bit wrap-around. SUB = A + ~B + 1.
- SLT: result = {0..,1} if signed A < signed B, else 0. The compare must be correct even when A-B overflows.
- SLL/SRL: logical shift of A by B[SHW-1:0]; upper bits of B are ignored.
- MFHI/MFLO: result = hi/lo as they stand at the accepting edge.
- Illegal code: result=0, illegal=1, done pulses, no other state changes.
- IDLE, start=1, sel=MULTU:
  - Go to MUL, busy=1 from the next cycle, counter=0, product register {hi,lo} cleared.
  - Each cycle in MUL: if the current multiplier bit is 1, add the multiplicand; shift right one bit; counter+1.
  - After WIDTH iterations: {hi,lo}=A*B unsigned (2*WIDTH bits), result=lo, done=1 for one cycle, busy=0, return to IDLE.
  - Total latency: accept edge k, done visible after edge k+WIDTH.
  - MULTU never sets overflow and clears illegal.
- hi/lo are architecturally visible only when done accompanies a MULTU. Their values are not defined while busy=1.
- start while busy=1: ignored, no queuing.
- start in the same cycle as done: accepted; back-to-back ops are allowed.
- done is never asserted except as a single-cycle pulse after an accepted op.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF B=0x00000001 -> result=0x80000000, overflow=1, done one cycle after accept; next SUB 5-3 -> result=2, overflow=0.
- SLT A=0x80000000 B=0x00000001 -> result=1. SLT A=0x7FFFFFFF B=0xFFFFFFFF -> result=0, with no corruption from overflow.
- SLL A=0x00000001 B=0xFFFFFFE4 (amount 4) -> 0x00000010. SRL A=0x80000000 B=31 -> 0x00000001.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy for 32 cycles; done after edge k+32; hi=0xFFFFFFFE, lo=0x00000001. Then MFHI -> result=0xFFFFFFFE.
- MULTU 3*5 with start pulsed at cycle 10 of busy -> ignored, lo=15. Then rst at cycle 5 of a second MULTU -> busy=0, hi=lo=0, no done.
- sel=111111 -> result=0, illegal=1, done pulse. Then AND 0xF0F0 & 0xFF00 -> result=0xF000, illegal=0.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Purpose: handshake and data bundle between the EX-stage issue logic and alu_ctrl_seq.
// Latency: none, this is wiring only.
// Backpressure: the issuer must hold off new requests while busy is high; start is dropped otherwise.
//
// Signals:
//   start           request, sampled only while busy=0
//   A, B, sel       operands and funct code, captured at the accepting edge
//   result, hi, lo  registered result and the architectural HI/LO pair
//   busy, done      multiply-in-progress flag and the one-cycle completion pulse
//   overflow        signed overflow of the last ADD/SUB
//   illegal         the last accepted funct code was not supported
interface alu_ctrl_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       sel;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             illegal;

  // Issue side: drives the request, observes the results.
  modport master (
    output start, A, B, sel,
    input  result, hi, lo, busy, done, overflow, illegal
  );

  // Execution unit side.
  modport slave (
    input  start, A, B, sel,
    output result, hi, lo, busy, done, overflow, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Purpose: sequential MIPS R-type execution unit (logic/arith/compare/shift, MULTU into HI/LO, MFHI/MFLO).
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MULTU (done after edge k+WIDTH).
// Backpressure: busy is high during a multiply; start is ignored (not queued) while busy.
//
// Ports:
//   clk   system clock, all state on posedge
//   rst   synchronous active-high reset, wins over start and aborts a multiply
//   bus   alu_ctrl_seq_if.slave: start/A/B/sel in; result/hi/lo/busy/done/overflow/illegal out
module alu_ctrl_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;
  logic             illegal_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  assign bus.result   = result_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.illegal  = illegal_q;

  // Single-cycle datapath, evaluated on the live inputs so that the
  // accepting edge captures exactly the operands present at accept.
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic [SHW-1:0]   shamt;

  always_comb begin
    add_res = bus.A + bus.B;
    sub_res = bus.A + (~bus.B) + WIDTH'(1);
    // Overflow: operand signs agree (ADD) or differ (SUB) and the result
    // sign moved away from A.
    add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_res[WIDTH-1] != bus.A[WIDTH-1]);
    sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_res[WIDTH-1] != bus.A[WIDTH-1]);
    // Direct signed compare rather than sign of A-B, so an overflowing
    // difference cannot flip the answer.
    slt_bit = ($signed(bus.A) < $signed(bus.B));
    shamt   = bus.B[SHW-1:0];
  end

  // One shift-add step: the multiplicand is added into the upper half when
  // the current multiplier bit is set, then the whole {carry,hi,lo} product
  // moves right one place. After WIDTH steps {hi,lo} holds the full product.
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    step_sum = {1'b0, hi_q} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], lo_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            case (bus.sel)
              F_AND:   result_q <= bus.A & bus.B;
              F_OR:    result_q <= bus.A | bus.B;
              F_ADD: begin
                result_q   <= add_res;
                overflow_q <= add_ovf;
              end
              F_SUB: begin
                result_q   <= sub_res;
                overflow_q <= sub_ovf;
              end
              F_SLT:   result_q <= {{(WIDTH-1){1'b0}}, slt_bit};
              F_SLL:   result_q <= bus.A << shamt;
              F_SRL:   result_q <= bus.A >> shamt;
              F_MFHI:  result_q <= hi_q;
              F_MFLO:  result_q <= lo_q;
              F_MULTU: begin
                // No completion pulse yet; it comes from the last iteration.
                done_q <= 1'b0;
                state  <= MUL;
                busy_q <= 1'b1;
                cnt    <= '0;
                hi_q   <= '0;
                lo_q   <= '0;
                mcand  <= bus.A;
                mplier <= bus.B;
              end
              default: begin
                result_q  <= '0;
                illegal_q <= 1'b1;
              end
            endcase
          end
        end

        MUL: begin
          hi_q   <= step_hi;
          lo_q   <= step_lo;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            result_q <= step_lo;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Purpose: directed self-checking bench for alu_ctrl_seq with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: exercises start-while-busy (ignored) and start-with-done (accepted back to back).
module tb_alu_ctrl_seq;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_BAD   = 6'b111111;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  alu_ctrl_seq_if #(.WIDTH(32)) bus ();

  alu_ctrl_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic do_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    bus.sel   = s;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Steps falling edges until done, bounded; counts cycles where busy dropped early.
  task automatic wait_done(output int n, output int busy_bad);
    n        = 0;
    busy_bad = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
      if (!bus.done && !bus.busy) busy_bad++;
    end
  endtask

  initial begin
    int n;
    int nb;
    int ndone;
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.sel   = '0;
    repeat (3) @(negedge clk);

    chk("rst_result",   {32'h0, bus.result}, 64'h0);
    chk("rst_hi",       {32'h0, bus.hi},     64'h0);
    chk("rst_lo",       {32'h0, bus.lo},     64'h0);
    chk("rst_busy",     {63'h0, bus.busy},     64'h0);
    chk("rst_done",     {63'h0, bus.done},     64'h0);
    chk("rst_overflow", {63'h0, bus.overflow}, 64'h0);
    chk("rst_illegal",  {63'h0, bus.illegal},  64'h0);
    rst = 1'b0;
    @(negedge clk);

    // ADD with signed overflow
    do_op(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_result", {32'h0, bus.result}, 64'h8000_0000);
    chk("add_ovf",    {63'h0, bus.overflow}, 64'h1);
    chk("add_done",   {63'h0, bus.done}, 64'h1);
    @(negedge clk);
    chk("add_done_pulse", {63'h0, bus.done}, 64'h0);

    // SLT must not touch overflow; negative vs positive
    do_op(F_SLT, 32'h8000_0000, 32'h0000_0001);
    chk("slt_neg",      {32'h0, bus.result}, 64'h1);
    chk("slt_keep_ovf", {63'h0, bus.overflow}, 64'h1);

    do_op(F_SUB, 32'd5, 32'd3);
    chk("sub_result", {32'h0, bus.result}, 64'h2);
    chk("sub_ovf",    {63'h0, bus.overflow}, 64'h0);

    // A-B overflows here; compare must still say "not less"
    do_op(F_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    chk("slt_ovf_case", {32'h0, bus.result}, 64'h0);

    do_op(F_SLL, 32'h0000_0001, 32'hFFFF_FFE4);
    chk("sll", {32'h0, bus.result}, 64'h10);
    do_op(F_SRL, 32'h8000_0000, 32'd31);
    chk("srl", {32'h0, bus.result}, 64'h1);

    // Full-scale MULTU: done after edge k+32
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_busy_k1", {63'h0, bus.busy}, 64'h1);
    chk("mul_done_k1", {63'h0, bus.done}, 64'h0);
    wait_done(n, nb);
    chk("mul_latency",  64'(n),  64'd32);
    chk("mul_busy_run", 64'(nb), 64'd0);
    chk("mul_hi",     {32'h0, bus.hi},     64'hFFFF_FFFE);
    chk("mul_lo",     {32'h0, bus.lo},     64'h0000_0001);
    chk("mul_result", {32'h0, bus.result}, 64'h0000_0001);
    chk("mul_busy_end", {63'h0, bus.busy}, 64'h0);

    // Start in the same cycle as done: accepted
    do_op(F_MFHI, 32'h0, 32'h0);
    chk("mfhi_result", {32'h0, bus.result}, 64'hFFFF_FFFE);
    chk("mfhi_done",   {63'h0, bus.done}, 64'h1);
    @(negedge clk);

    // MULTU 3*5 with an ADD request during busy cycle 10 that must be dropped
    do_op(F_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    do_op(F_ADD, 32'd1, 32'd1);
    wait_done(n, nb);
    chk("mul15_latency", 64'(n + 10), 64'd32);
    chk("mul15_lo",      {32'h0, bus.lo},     64'd15);
    chk("mul15_hi",      {32'h0, bus.hi},     64'd0);
    chk("mul15_result",  {32'h0, bus.result}, 64'd15);
    @(negedge clk);
    chk("ignored_no_done",    {63'h0, bus.done}, 64'h0);
    chk("ignored_result_kept", {32'h0, bus.result}, 64'd15);

    // Reset during busy cycle 5 of a second multiply
    do_op(F_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'h0, bus.busy}, 64'h0);
    chk("abort_hi",   {32'h0, bus.hi}, 64'h0);
    chk("abort_lo",   {32'h0, bus.lo}, 64'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // Illegal code, bracketed by legal ops
    do_op(F_OR, 32'h1, 32'h2);
    chk("or_result", {32'h0, bus.result}, 64'h3);
    do_op(F_BAD, 32'h1234, 32'h5678);
    chk("ill_result", {32'h0, bus.result}, 64'h0);
    chk("ill_flag",   {63'h0, bus.illegal}, 64'h1);
    chk("ill_done",   {63'h0, bus.done}, 64'h1);
    do_op(F_AND, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and_result", {32'h0, bus.result}, 64'hF000);
    chk("and_illegal", {63'h0, bus.illegal}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
